hilo_div_ctrl: RTL

//   Initiator side of the Start/Ready divider handshake. Accepts DIV/DIVU from EX and latches the operands.

---
 rtl/hilo_div_ctrl_pkg.sv | 6 +
 rtl/hilo_div_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// hilo_div_ctrl_pkg: shared state encoding and default sizes for the HI/LO divide controller
package hilo_div_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int WDOG_MAX_DEF = 15;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} state_t;
endpackage

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: Start/Ready divide initiator owning HI/LO; DIV_ZERO_FAST_EN short-circuits divide-by-zero
module hilo_div_ctrl #(
  parameter int DATA_W = hilo_div_ctrl_pkg::DATA_W_DEF,
  parameter int WDOG_MAX = hilo_div_ctrl_pkg::WDOG_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_div_req,
  input  logic                  i_div_signed,
  input  logic [DATA_W-1:0]     i_op_a,
  input  logic [DATA_W-1:0]     i_op_b,
  input  logic                  i_flush,
  input  logic                  i_hi_we,
  input  logic                  i_lo_we,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic                  o_stall,
  output logic                  o_div_start,
  output logic                  o_div_sgn,
  output logic [DATA_W-1:0]     o_div_a,
  output logic [DATA_W-1:0]     o_div_b,
  input  logic                  i_div_ready,
  input  logic [2*DATA_W-1:0]   i_div_result,
  output logic [DATA_W-1:0]     o_hi,
  output logic [DATA_W-1:0]     o_lo,
  output logic                  o_div_err
);
  import hilo_div_ctrl_pkg::*;
  state_t r_state;
  logic r_start, r_sgn, r_discard, r_err;
  logic [DATA_W-1:0] r_a, r_b, r_hi, r_lo;
  logic [3:0] r_wdog;
  logic w_fast_blk, w_zero, w_accept, w_mt_ok;
`ifdef DIV_ZERO_FAST_EN
  logic r_fast;
  assign w_fast_blk = r_fast;
  assign w_zero = i_op_b == '0;
  always_ff @(posedge clk) r_fast <= rst && w_accept && w_zero;
`else
  assign w_fast_blk = 1'b0;
  assign w_zero = 1'b0;
`endif
  // r_fast marks the cycle after a short-circuited divide: the DIV is done, so don't re-accept it
  assign w_accept = r_state == ST_IDLE && i_div_req && !i_flush && !w_fast_blk;
  // The ready cycle releases the pipeline, so the result edge is also the edge the DIV retires on
  assign o_stall = w_accept || (r_state == ST_ISSUE && !i_div_ready) || (r_state == ST_DRAIN && i_div_req);
  assign w_mt_ok = r_state != ST_ISSUE;
  assign o_div_start = r_start;
  assign o_div_sgn = r_sgn;
  assign o_div_a = r_a;
  assign o_div_b = r_b;
  assign o_hi = r_hi;
  assign o_lo = r_lo;
  assign o_div_err = r_err;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_sgn <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_discard <= 1'b0;
      r_err <= 1'b0;
      r_wdog <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_zero) begin
            r_hi <= i_op_a;
            r_lo <= '1;
          end else if (w_accept) begin
            r_a <= i_op_a;
            r_b <= i_op_b;
            r_sgn <= i_div_signed;
            r_start <= 1'b1;
            r_wdog <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_flush) r_discard <= 1'b1;
          if (i_div_ready) begin
            if (!(r_discard || i_flush)) {r_hi, r_lo} <= i_div_result;
            r_start <= 1'b0;
            r_state <= ST_DRAIN;
          end
          if (r_wdog == 4'(WDOG_MAX - 1)) r_err <= 1'b1;
          else r_wdog <= r_wdog + 4'd1;
        end
        ST_DRAIN: begin
          if (!i_div_ready) begin
            r_discard <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_mt_ok && i_hi_we) r_hi <= i_wdata;
      if (w_mt_ok && i_lo_we) r_lo <= i_wdata;
    end
  end
endmodule
